time_ctrl: RTL and testbench
============================

# time_ctrl

Timekeeping and set-mode controller for the clock display path. Generates the BCD time digits, the one-cycle seconds pulse and the periodic refresh strobe consumed by `decoder`, with all outputs wired one-to-one to its inputs. Runs the 24-hour HH:MM:SS count in normal mode. In set mode it freezes seconds and lets debounced button pulses step hours and minutes.

## Interface
- `C_SEC_PER`, 50_000_000: clock cycles per second; must be ≥ 2.
- `C_VALID_PER`, 50_000: clock cycles per refresh strobe; must be ≥ 2.

- `i_CLK`  in  1  system clock; all logic on the rising edge.
- `i_RST_N`  in  1  reset, asynchronous, active-low.
- `i_SET`  in  1  set-mode request, level, already synchronous to `i_CLK`.
- `i_BTN_HR`  in  1  hour-increment pulse, one cycle, already debounced.
- `i_BTN_MN`  in  1  minute-increment pulse, one cycle, already debounced.
- `o_SET`  out  1  1 while the FSM is in SET.
- `o_HR_T`  out  2  hours tens digit, BCD 0..2.
- `o_HR_U`  out  4  hours units digit, BCD 0..9; 0..3 when `o_HR_T` = 2.
- `o_MN_T`  out  3  minutes tens digit, BCD 0..5.
- `o_MN_U`  out  4  minutes units digit, BCD 0..9.
- `o_SEC`  out  1  one-cycle pulse per elapsed second; RUN only.
- `o_VALID`  out  1  one-cycle refresh strobe.

## Operation
- All outputs are registered.
- Reset values:
  - state RUN, time 00:00:00, prescaler 0, refresh counter 0.
  - all outputs 0.
  - Reset asserted mid-operation returns to these values immediately, with no partial state retained.
- Prescaler counts 0..C_SEC_PER-1 in RUN. On the terminal count:
  - the prescaler wraps to 0;
  - `o_SEC` is 1 for the following cycle;
  - seconds (internal 6-bit binary, 0..59) increment.
- Carry chain, all digits updating in the same cycle:
  - seconds 59→0 carries into `o_MN_U`;
  - `o_MN_U` 9→0 carries into `o_MN_T`;
  - `o_MN_T` 5→0 carries into hours;
  - 23:59:59 → 00:00:00.
- Hours BCD pair: units 9→0 with tens +1; on 23→00 both digits clear.
- FSM, two states:
  - RUN → SET when `i_SET` = 1 is sampled.
  - SET → RUN when `i_SET` = 0 is sampled.
- On entry to SET: seconds and prescaler clear to 0, and stay 0 while in SET. `o_SEC` stays 0 in SET.
- In SET, each sampled `i_BTN_MN` pulse increments minutes 59→00. There is no carry into hours.
- In SET, each sampled `i_BTN_HR` pulse increments hours 23→00.
- Both buttons in the same cycle: both apply independently.
- Buttons sampled in RUN are ignored, including in the cycle where `i_SET` rises. The FSM is still RUN at that edge.
- Buttons sampled in the cycle where the FSM is SET and `i_SET` = 0 are applied; the exit takes effect at the same edge.
- Refresh counter counts 0..C_VALID_PER-1 continuously in both states. On the terminal count, `o_VALID` is 1 for the following cycle.
- Any time change forces `o_VALID` = 1 in the cycle the new digits appear. This covers a second carry into minutes and a button increment. The periodic strobe is not delayed by this, and a coincident strobe gives a single pulse.

## Timing
- Seconds pulse period is exactly C_SEC_PER cycles. The first `o_SEC` after reset release or after SET exit comes C_SEC_PER cycles after that edge.
- Digit latency is 1 cycle: an edge sampling a terminal count or button changes the digits at that edge. The new digits are valid in the same cycle as the `o_SEC` or `o_VALID` pulse.
- `o_SET` follows the FSM state: it changes at the edge that samples the `i_SET` transition.
- Refresh strobe period is exactly C_VALID_PER cycles, unaffected by mode changes. The first strobe comes C_VALID_PER cycles after reset release.
- `o_SEC` and `o_VALID` are never high for two consecutive cycles, except for a forced pulse adjacent to a periodic pulse.
- Prescaler width is $clog2(C_SEC_PER) and refresh counter width is $clog2(C_VALID_PER). Compares are on the exact terminal value, with no overflow reliance.

## Test plan
All scenarios use C_SEC_PER = 10 and C_VALID_PER = 4.
- **Reset:** release `i_RST_N` → all outputs 0. `o_VALID` at cycle 4, then every 4 cycles. `o_SEC` at cycle 10, then every 10 cycles.
- **Midnight rollover:** set 23:59 via SET and buttons, exit, run 60 seconds → after the 60th `o_SEC`, digits read 00:00 with the forced `o_VALID` in the same cycle.
- **Minute carry:** run 60 `o_SEC` pulses from 00:00 → 00:01 appears together with the 60th pulse. After 600 pulses the display reads 00:10.
- **Set wraps:** in SET, 60 `i_BTN_MN` pulses → 00:59 then 00:00 with hours unchanged. 24 `i_BTN_HR` pulses → hours cycle back to 00. Each press yields `o_VALID` the next cycle.
- **Set edge cases:**
  - button in the `i_SET` rising cycle → ignored;
  - button in the exit cycle → applied;
  - both buttons together at 09:09 → 10:10;
  - no `o_SEC` in SET;
  - first `o_SEC` exactly 10 cycles after exit.
- **Mid-operation reset:** assert `i_RST_N` = 0 asynchronously mid-SET at 12:34 → outputs 0 and FSM RUN immediately. After release, counting restarts from 00:00:00.

Source files
------------

// File: rtl/time_ctrl_if.sv
// Display-path bundle between time_ctrl and its neighbours: set/button inputs
// and the BCD digits, seconds pulse and refresh strobe consumed by decoder.
interface time_ctrl_if;
   logic       i_SET;
   logic       i_BTN_HR;
   logic       i_BTN_MN;
   logic       o_SET;
   logic [1:0] o_HR_T;
   logic [3:0] o_HR_U;
   logic [2:0] o_MN_T;
   logic [3:0] o_MN_U;
   logic       o_SEC;
   logic       o_VALID;

   modport master (
      output i_SET, i_BTN_HR, i_BTN_MN,
      input  o_SET, o_HR_T, o_HR_U, o_MN_T, o_MN_U, o_SEC, o_VALID
   );

   modport slave (
      input  i_SET, i_BTN_HR, i_BTN_MN,
      output o_SET, o_HR_T, o_HR_U, o_MN_T, o_MN_U, o_SEC, o_VALID
   );
endinterface

// File: rtl/time_ctrl.sv
// 24-hour HH:MM:SS timekeeper with a RUN/SET mode FSM, seconds pulse and
// periodic display refresh strobe; every output comes straight from a flop.
module time_ctrl #(
   parameter int unsigned C_SEC_PER   = 50_000_000,
   parameter int unsigned C_VALID_PER = 50_000
) (
   input  logic        i_CLK,
   input  logic        i_RST_N,
   time_ctrl_if.slave  bus
);

   localparam int unsigned PW = $clog2(C_SEC_PER);
   localparam int unsigned VW = $clog2(C_VALID_PER);
   localparam logic [PW-1:0] PRESC_LAST = PW'(C_SEC_PER - 32'd1);
   localparam logic [VW-1:0] REFR_LAST  = VW'(C_VALID_PER - 32'd1);

   typedef enum logic [0:0] {
      ST_RUN = 1'b0,
      ST_SET = 1'b1
   } state_t;

   // Minutes BCD pair increment, 59 wraps to 00.
   function automatic logic [6:0] inc_min(input logic [2:0] t, input logic [3:0] u);
      logic [6:0] r;
      if (u == 4'd9) begin
         if (t == 3'd5) begin
            r = {3'd0, 4'd0};
         end else begin
            r = {t + 3'd1, 4'd0};
         end
      end else begin
         r = {t, u + 4'd1};
      end
      return r;
   endfunction

   // Hours BCD pair increment, 23 wraps to 00.
   function automatic logic [5:0] inc_hr(input logic [1:0] t, input logic [3:0] u);
      logic [5:0] r;
      if ((t == 2'd2) && (u == 4'd3)) begin
         r = {2'd0, 4'd0};
      end else if (u == 4'd9) begin
         r = {t + 2'd1, 4'd0};
      end else begin
         r = {t, u + 4'd1};
      end
      return r;
   endfunction

   state_t         state_r, state_s;
   logic [PW-1:0]  presc_r, presc_s;
   logic [VW-1:0]  refr_r,  refr_s;
   logic [5:0]     sec_r,   sec_s;
   logic [1:0]     hr_t_r,  hr_t_s;
   logic [3:0]     hr_u_r,  hr_u_s;
   logic [2:0]     mn_t_r,  mn_t_s;
   logic [3:0]     mn_u_r,  mn_u_s;
   logic           set_r, sec_pls_r, sec_pls_s, valid_r, valid_s;
   logic           chg_s, refr_tc_s;
   logic [5:0]     hr_inc_s;
   logic [6:0]     mn_inc_s;

   // Next-state decode: mode FSM, prescaler, carry chain, button steps, refresh.
   always_comb begin
      state_s   = state_r;
      presc_s   = presc_r;
      sec_s     = sec_r;
      hr_t_s    = hr_t_r;
      hr_u_s    = hr_u_r;
      mn_t_s    = mn_t_r;
      mn_u_s    = mn_u_r;
      sec_pls_s = 1'b0;
      chg_s     = 1'b0;
      hr_inc_s  = inc_hr(hr_t_r, hr_u_r);
      mn_inc_s  = inc_min(mn_t_r, mn_u_r);

      case (state_r)
         ST_RUN: begin
            if (bus.i_SET) begin
               // Buttons on the entry edge are deliberately ignored.
               state_s = ST_SET;
               presc_s = {PW{1'b0}};
               sec_s   = 6'd0;
            end else if (presc_r == PRESC_LAST) begin
               presc_s   = {PW{1'b0}};
               sec_pls_s = 1'b1;
               if (sec_r == 6'd59) begin
                  sec_s            = 6'd0;
                  chg_s            = 1'b1;
                  {mn_t_s, mn_u_s} = mn_inc_s;
                  if ((mn_t_r == 3'd5) && (mn_u_r == 4'd9)) begin
                     {hr_t_s, hr_u_s} = hr_inc_s;
                  end else begin
                     {hr_t_s, hr_u_s} = {hr_t_r, hr_u_r};
                  end
               end else begin
                  sec_s = sec_r + 6'd1;
               end
            end else begin
               presc_s = presc_r + PW'(1);
            end
         end
         ST_SET: begin
            presc_s = {PW{1'b0}};
            sec_s   = 6'd0;
            if (bus.i_SET) begin
               state_s = ST_SET;
            end else begin
               state_s = ST_RUN;
            end
            if (bus.i_BTN_MN) begin
               {mn_t_s, mn_u_s} = mn_inc_s;
            end else begin
               {mn_t_s, mn_u_s} = {mn_t_r, mn_u_r};
            end
            if (bus.i_BTN_HR) begin
               {hr_t_s, hr_u_s} = hr_inc_s;
            end else begin
               {hr_t_s, hr_u_s} = {hr_t_r, hr_u_r};
            end
            chg_s = bus.i_BTN_MN | bus.i_BTN_HR;
         end
         default: begin
            state_s = ST_RUN;
            presc_s = {PW{1'b0}};
            sec_s   = 6'd0;
         end
      endcase

      refr_tc_s = (refr_r == REFR_LAST);
      if (refr_tc_s) begin
         refr_s = {VW{1'b0}};
      end else begin
         refr_s = refr_r + VW'(1);
      end
      valid_s = refr_tc_s | chg_s;
   end

   // State and output registers; async reset returns everything to 00:00:00 RUN.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_r   <= ST_RUN;
         presc_r   <= {PW{1'b0}};
         refr_r    <= {VW{1'b0}};
         sec_r     <= 6'd0;
         hr_t_r    <= 2'd0;
         hr_u_r    <= 4'd0;
         mn_t_r    <= 3'd0;
         mn_u_r    <= 4'd0;
         set_r     <= 1'b0;
         sec_pls_r <= 1'b0;
         valid_r   <= 1'b0;
      end else begin
         state_r   <= state_s;
         presc_r   <= presc_s;
         refr_r    <= refr_s;
         sec_r     <= sec_s;
         hr_t_r    <= hr_t_s;
         hr_u_r    <= hr_u_s;
         mn_t_r    <= mn_t_s;
         mn_u_r    <= mn_u_s;
         set_r     <= (state_s == ST_SET);
         sec_pls_r <= sec_pls_s;
         valid_r   <= valid_s;
      end
   end

   assign bus.o_SET   = set_r;
   assign bus.o_HR_T  = hr_t_r;
   assign bus.o_HR_U  = hr_u_r;
   assign bus.o_MN_T  = mn_t_r;
   assign bus.o_MN_U  = mn_u_r;
   assign bus.o_SEC   = sec_pls_r;
   assign bus.o_VALID = valid_r;

endmodule

// File: tb/tb_time_ctrl.sv
// Directed bench for time_ctrl with C_SEC_PER = 10 and C_VALID_PER = 4;
// drives and samples on the falling edge, expectations computed by hand.
module tb_time_ctrl;
   localparam int unsigned SP = 10;
   localparam int unsigned VP = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_total = 0;
   int   n_pass  = 0;

   time_ctrl_if bus ();

   time_ctrl #(.C_SEC_PER(SP), .C_VALID_PER(VP)) dut (
      .i_CLK   (clk),
      .i_RST_N (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] disp();
      return {2'b00, bus.o_HR_T, bus.o_HR_U, 1'b0, bus.o_MN_T, bus.o_MN_U};
   endfunction

   function automatic logic [15:0] bcd(input int h, input int m);
      logic [3:0] a, b, c, d;
      a = 4'(h / 10);
      b = 4'(h % 10);
      c = 4'(m / 10);
      d = 4'(m % 10);
      return {a, b, c, d};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic press(input logic hr, input logic mn);
      bus.i_BTN_HR = hr;
      bus.i_BTN_MN = mn;
      step();
      bus.i_BTN_HR = 1'b0;
      bus.i_BTN_MN = 1'b0;
   endtask

   task automatic set_time(input int h, input int m);
      for (int i = 0; i < h; i++) begin
         press(1'b1, 1'b0);
         step();
      end
      for (int i = 0; i < m; i++) begin
         press(1'b0, 1'b1);
         step();
      end
   endtask

   // Returns at the falling edge of the cycle holding the n-th o_SEC pulse.
   task automatic wait_secs(input int n);
      int seen = 0;
      int cyc  = 0;
      while ((seen < n) && (cyc < n * SP + 20)) begin
         step();
         cyc++;
         if (bus.o_SEC) seen++;
      end
      chk("sec_count", seen, n);
   endtask

   // Cycle index of the first o_SEC after the current edge, 0 if none.
   task automatic first_sec(output int k);
      k = 0;
      for (int i = 1; i <= SP + 5; i++) begin
         step();
         if (bus.o_SEC && (k == 0)) k = i;
      end
   endtask

   initial begin
      int k;
      int sec_seen;
      bus.i_SET    = 1'b0;
      bus.i_BTN_HR = 1'b0;
      bus.i_BTN_MN = 1'b0;

      // Reset values and periodic strobe / pulse positions
      @(negedge clk);
      chk("rst_disp",  disp(),      16'h0000);
      chk("rst_set",   bus.o_SET,   1'b0);
      chk("rst_sec",   bus.o_SEC,   1'b0);
      chk("rst_valid", bus.o_VALID, 1'b0);
      rst_n = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         chk("valid_period", bus.o_VALID, ((c % VP) == 0) ? 1'b1 : 1'b0);
         chk("sec_period",   bus.o_SEC,   ((c % SP) == 0) ? 1'b1 : 1'b0);
      end

      // Minute carry in RUN
      do_reset();
      wait_secs(59);
      chk("carry_59", disp(), bcd(0, 0));
      wait_secs(1);
      chk("carry_60", disp(), bcd(0, 1));
      chk("carry_60_valid", bus.o_VALID, 1'b1);
      wait_secs(540);
      chk("carry_600", disp(), bcd(0, 10));

      // Set-mode wraps, one forced strobe per press
      do_reset();
      bus.i_SET = 1'b1;
      step();
      chk("set_enter", bus.o_SET, 1'b1);
      sec_seen = 0;
      for (int i = 1; i <= 60; i++) begin
         press(1'b0, 1'b1);
         if (bus.o_SEC) sec_seen++;
         chk("set_mn_valid", bus.o_VALID, 1'b1);
         chk("set_mn", disp(), bcd(0, i % 60));
         step();
         if (bus.o_SEC) sec_seen++;
      end
      for (int i = 1; i <= 24; i++) begin
         press(1'b1, 1'b0);
         if (bus.o_SEC) sec_seen++;
         chk("set_hr_valid", bus.o_VALID, 1'b1);
         chk("set_hr", disp(), bcd(i % 24, 0));
         step();
         if (bus.o_SEC) sec_seen++;
      end
      chk("set_no_sec", sec_seen, 0);

      // Set edge cases
      do_reset();
      bus.i_SET = 1'b1;
      press(1'b1, 1'b1);
      chk("rise_set", bus.o_SET, 1'b1);
      chk("rise_ignored", disp(), bcd(0, 0));
      set_time(9, 9);
      chk("at_0909", disp(), bcd(9, 9));
      press(1'b1, 1'b1);
      chk("both_btn", disp(), bcd(10, 10));
      chk("both_valid", bus.o_VALID, 1'b1);
      sec_seen = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (bus.o_SEC) sec_seen++;
      end
      chk("idle_set_no_sec", sec_seen, 0);
      bus.i_SET = 1'b0;
      press(1'b0, 1'b1);
      chk("exit_set", bus.o_SET, 1'b0);
      chk("exit_btn_applied", disp(), bcd(10, 11));
      first_sec(k);
      chk("exit_first_sec", k, SP);

      // Midnight rollover
      do_reset();
      bus.i_SET = 1'b1;
      step();
      set_time(23, 59);
      chk("at_2359", disp(), bcd(23, 59));
      bus.i_SET = 1'b0;
      step();
      wait_secs(59);
      chk("midnight_59", disp(), bcd(23, 59));
      wait_secs(1);
      chk("midnight", disp(), bcd(0, 0));
      chk("midnight_valid", bus.o_VALID, 1'b1);

      // Asynchronous reset in the middle of SET
      do_reset();
      bus.i_SET = 1'b1;
      step();
      set_time(12, 34);
      chk("at_1234", disp(), bcd(12, 34));
      bus.i_SET = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("async_disp",  disp(),      16'h0000);
      chk("async_set",   bus.o_SET,   1'b0);
      chk("async_valid", bus.o_VALID, 1'b0);
      chk("async_sec",   bus.o_SEC,   1'b0);
      @(negedge clk);
      step();
      rst_n = 1'b1;
      first_sec(k);
      chk("restart_first_sec", k, SP);
      chk("restart_disp", disp(), bcd(0, 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
